// File: rtl/pool1_frame_buffer.sv
// pool1_frame_buffer
// -----------------------------------------------------------------------------
// Ping-pong frame buffer behind the first 2x2 max-pool stage. Pooled pixels
// arrive as a sparse stream with no backpressure. They are captured frame by
// frame, in raster order, into one of two banks. Each complete bank is then
// replayed to the next convolution stage over a valid/ready handshake. A frame
// is dropped whole if its target bank is still waiting to be drained when the
// frame starts.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   in_valid            one pooled pixel present this cycle
//   in_1/in_2/in_3      channel samples of that pixel (DATA_W each)
//   out_ready           downstream accepts the current output pixel
//   out_valid           output pixel valid
//   out_1/out_2/out_3   replayed channel samples (DATA_W each)
//   out_row/out_col     raster coordinates of the output pixel
//   out_last            final pixel of the frame
//   overflow            sticky: at least one frame was dropped
// -----------------------------------------------------------------------------
module pool1_frame_buffer #(
    parameter int IMG_WIDTH  = 12,
    parameter int IMG_HEIGHT = 12,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2,
    output logic [DATA_W-1:0] out_3,
    output logic [3:0]        out_row,
    output logic [3:0]        out_col,
    output logic              out_last,
    output logic              overflow
);

    localparam int FRAME  = IMG_WIDTH * IMG_HEIGHT;
    localparam int PTR_W  = $clog2(FRAME);
    localparam int WORD_W = 3 * DATA_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME - 1);
    localparam logic [PTR_W-1:0] ZERO_PTR = PTR_W'(0);
    localparam logic [3:0]       LAST_COL = 4'(IMG_WIDTH - 1);

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // One-hot mask selecting a bank's full flag.
    function automatic logic [1:0] bank_onehot(input logic bank);
        return {bank, ~bank};
    endfunction

    // Frame storage: two banks, each pixel packed as {ch1, ch2, ch3}.
    logic [WORD_W-1:0] mem_q [2][FRAME];

    // Write-side state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             wr_bank_q, wr_bank_d;
    logic             drop_q, drop_d;
    logic             overflow_q, overflow_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       full_set_s;
    logic [1:0]       full_clr_s;
    logic             drop_now_s;
    logic             wr_en_s;

    // Read-side state
    rd_state_e        rd_state_q, rd_state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             rd_bank_q, rd_bank_d;
    logic             out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [3:0]       out_row_q, out_row_d;
    logic [3:0]       out_col_q, out_col_d;
    logic             out_last_q, out_last_d;
    logic [PTR_W-1:0] rd_next_ptr_s;
    logic [WORD_W-1:0] rd_data_s;

    // The drop decision is taken on the first pixel of a frame from the
    // pre-edge full flag and then held for the rest of that frame.
    assign drop_now_s = (wr_ptr_q == ZERO_PTR) ? full_q[wr_bank_q] : drop_q;
    assign wr_en_s    = in_valid && !drop_now_s;

    // Entry to present next: entry 0 when a new frame is loaded from idle,
    // otherwise the entry after the one currently on the outputs.
    assign rd_next_ptr_s = ((rd_state_q == RD_STREAM) && (rd_ptr_q != LAST_PTR))
                           ? (rd_ptr_q + PTR_W'(1)) : ZERO_PTR;
    assign rd_data_s     = mem_q[rd_bank_q][rd_next_ptr_s];

    // Capture non-dropped pixels into the current write bank (contents not reset).
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_bank_q][wr_ptr_q] <= {in_1, in_2, in_3};
        end
    end

    // Write pointer, bank toggle, drop and overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        wr_bank_d  = wr_bank_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        full_set_s = 2'b00;
        if (in_valid) begin
            drop_d = drop_now_s;
            // Flag the loss as soon as the frame is known to be dropped.
            if (drop_now_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
            // The pointer advances even for dropped frames to stay frame-aligned.
            if (wr_ptr_q == LAST_PTR) begin
                wr_ptr_d = ZERO_PTR;
                if (!drop_now_s) begin
                    full_set_s = bank_onehot(wr_bank_q);
                    wr_bank_d  = ~wr_bank_q;
                end else begin
                    full_set_s = 2'b00;
                    wr_bank_d  = wr_bank_q;
                end
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end else begin
            drop_d = drop_q;
        end
    end

    // Read FSM next-state and output-register next-state.
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_ptr_d    = rd_ptr_q;
        rd_bank_d   = rd_bank_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        full_clr_s  = 2'b00;
        case (rd_state_q)
            RD_IDLE: begin
                out_valid_d = 1'b0;
                if (full_q[rd_bank_q]) begin
                    out_data_d  = rd_data_s;
                    out_valid_d = 1'b1;
                    rd_ptr_d    = ZERO_PTR;
                    out_row_d   = 4'd0;
                    out_col_d   = 4'd0;
                    out_last_d  = (rd_next_ptr_s == LAST_PTR);
                    rd_state_d  = RD_STREAM;
                end else begin
                    out_last_d  = 1'b0;
                    rd_state_d  = RD_IDLE;
                end
            end
            RD_STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (rd_ptr_q != LAST_PTR) begin
                        rd_ptr_d   = rd_next_ptr_s;
                        out_data_d = rd_data_s;
                        out_last_d = (rd_next_ptr_s == LAST_PTR);
                        if (out_col_q == LAST_COL) begin
                            out_col_d = 4'd0;
                            out_row_d = out_row_q + 4'd1;
                        end else begin
                            out_col_d = out_col_q + 4'd1;
                            out_row_d = out_row_q;
                        end
                    end else begin
                        // Last pixel accepted: release the bank and go idle
                        // for one cycle before the next frame.
                        full_clr_s  = bank_onehot(rd_bank_q);
                        rd_bank_d   = ~rd_bank_q;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        rd_state_d  = RD_IDLE;
                    end
                end else begin
                    rd_state_d = RD_STREAM;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                rd_state_d  = RD_IDLE;
            end
        endcase
    end

    // Set and clear never target the same bank in one cycle, so both apply.
    assign full_d = (full_q & ~full_clr_s) | full_set_s;

    // State registers for both the write and the read side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= ZERO_PTR;
            wr_bank_q   <= 1'b0;
            drop_q      <= 1'b0;
            overflow_q  <= 1'b0;
            full_q      <= 2'b00;
            rd_state_q  <= RD_IDLE;
            rd_ptr_q    <= ZERO_PTR;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {WORD_W{1'b0}};
            out_row_q   <= 4'd0;
            out_col_q   <= 4'd0;
            out_last_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_bank_q   <= wr_bank_d;
            drop_q      <= drop_d;
            overflow_q  <= overflow_d;
            full_q      <= full_d;
            rd_state_q  <= rd_state_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_bank_q   <= rd_bank_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_1     = out_data_q[3*DATA_W-1:2*DATA_W];
    assign out_2     = out_data_q[2*DATA_W-1:DATA_W];
    assign out_3     = out_data_q[DATA_W-1:0];
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pool1_frame_buffer.sv
// Scoreboard bench for pool1_frame_buffer: stimulus pushes expected output
// words into a queue; an independent monitor pops and compares on every
// output handshake and also checks hold-while-stalled and the inter-frame
// bubble.
module tb_pool1_frame_buffer;

    localparam int W     = 12;
    localparam int H     = 12;
    localparam int DW    = 8;
    localparam int FRAME = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_1 = 8'd0, in_2 = 8'd0, in_3 = 8'd0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_1, out_2, out_3;
    logic [3:0]    out_row, out_col;
    logic          out_last;
    logic          overflow;

    int checks = 0;
    int failures = 0;
    bit bp_rand = 1'b0;
    logic [32:0] sb [$];

    pool1_frame_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_1(out_1), .out_2(out_2), .out_3(out_3),
        .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Expected output word {ch1, ch2, ch3, row, col, last} for pixel k.
    function automatic logic [32:0] exp_word(input int seed, input int k);
        logic [7:0] a, b, c;
        a = 8'(k + seed);
        b = 8'(k + 1 + seed);
        c = 8'(255 - k - seed);
        return {a, b, c, 4'(k / W), 4'(k % W), (k == FRAME - 1)};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock step; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_rand) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Drive pixels from..to of a frame; gap_mode 0 none, 1 every other cycle, 2 random.
    task automatic send_range(input int seed, input int from, input int to, input int gap_mode);
        int g;
        for (int k = from; k <= to; k++) begin
            in_valid = 1'b1;
            in_1 = 8'(k + seed);
            in_2 = 8'(k + 1 + seed);
            in_3 = 8'(255 - k - seed);
            tick();
            in_valid = 1'b0;
            if (k != to) begin
                g = (gap_mode == 0) ? 0 : ((gap_mode == 1) ? 1 : int'($urandom_range(0, 3)));
                repeat (g) tick();
            end
        end
    endtask

    task automatic send_frame(input int seed, input int gap_mode, input bit push);
        if (push) begin
            for (int k = 0; k < FRAME; k++) sb.push_back(exp_word(seed, k));
        end
        send_range(seed, 0, FRAME - 1, gap_mode);
    endtask

    // Wait until every expected pixel has been emitted and the output is idle.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            failures++;
            $display("FAIL drain_timeout actual_pending=%0d required_pending=0", sb.size());
        end
    endtask

    // Wait until at most one captured frame is still pending output.
    task automatic wait_room(input int budget);
        int n;
        n = 0;
        while (sb.size() > FRAME && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() > FRAME) begin
            failures++;
            $display("FAIL room_timeout actual_pending=%0d required_max=%0d", sb.size(), FRAME);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 33'(out_valid), 33'd0);
        check({tag, "_ch1"},   33'(out_1),     33'd0);
        check({tag, "_ch2"},   33'(out_2),     33'd0);
        check({tag, "_ch3"},   33'(out_3),     33'd0);
        check({tag, "_row"},   33'(out_row),   33'd0);
        check({tag, "_col"},   33'(out_col),   33'd0);
        check({tag, "_last"},  33'(out_last),  33'd0);
        check({tag, "_ovf"},   33'(overflow),  33'd0);
    endtask

    // Monitor: compare on handshakes, check stall-hold and post-frame bubble.
    logic [32:0] cur_s;
    logic [32:0] held;
    bit hold_pend = 1'b0;
    bit last_acc = 1'b0;
    assign cur_s = {out_1, out_2, out_3, out_row, out_col, out_last};

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend <= 1'b0;
            last_acc  <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 33'(out_valid), 33'd1);
                check("hold_data", cur_s, held);
            end
            if (last_acc) check("bubble", 33'(out_valid), 33'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none", cur_s);
                end else begin
                    check("pixel", cur_s, sb.pop_front());
                end
            end
            hold_pend <= out_valid && !out_ready;
            held      <= cur_s;
            last_acc  <= out_valid && out_ready && out_last;
        end
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single frame, ready held high, pixels every other cycle
        out_ready = 1'b1;
        send_frame(0, 1, 1'b1);
        @(negedge clk);
        check("lat_not_yet", 33'(out_valid), 33'd0);
        @(negedge clk);
        check("lat_first_valid", 33'(out_valid), 33'd1);
        drain(400);
        check("single_ovf", 33'(overflow), 33'd0);

        // Back-to-back frames without gaps
        send_frame(1, 0, 1'b1);
        send_frame(2, 0, 1'b1);
        drain(600);
        check("b2b_ovf", 33'(overflow), 33'd0);

        // Random backpressure and random input gaps, three frames
        bp_rand = 1'b1;
        for (int f = 3; f < 6; f++) begin
            wait_room(3000);
            send_frame(f, 2, 1'b1);
        end
        drain(3000);
        bp_rand = 1'b0;
        out_ready = 1'b1;
        check("rand_ovf", 33'(overflow), 33'd0);

        // Same-edge: frame start coincides with acceptance of bank 0's last pixel
        out_ready = 1'b0;
        send_frame(6, 0, 1'b1);
        send_frame(7, 0, 1'b1);
        check("same_edge_pre_ovf", 33'(overflow), 33'd0);
        out_ready = 1'b1;
        repeat (FRAME - 1) tick();
        send_frame(8, 0, 1'b0);
        check("same_edge_ovf", 33'(overflow), 33'd1);
        drain(800);

        // Reset mid-stream with a second frame half captured
        out_ready = 1'b0;
        send_frame(9, 0, 1'b1);
        out_ready = 1'b1;
        send_range(10, 0, 71, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(11, 1, 1'b1);
        drain(500);
        check("post_rst_ovf", 33'(overflow), 33'd0);

        // Overflow: A and B held, C dropped, D accepted afterwards
        out_ready = 1'b0;
        send_frame(12, 0, 1'b1);
        send_frame(13, 0, 1'b1);
        check("ovf_before_c", 33'(overflow), 33'd0);
        send_range(14, 0, 0, 0);
        check("ovf_at_c_first", 33'(overflow), 33'd1);
        send_range(14, 1, FRAME - 1, 0);
        out_ready = 1'b1;
        drain(800);
        send_frame(15, 1, 1'b1);
        drain(500);
        check("ovf_sticky", 33'(overflow), 33'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
